// File: rtl/as_lsu_ctrl_if.sv
// Core-side request/response bundle and SRAM-side bundle for the load/store controller.
// Signal names mirror the controller's port list so both ends read the same way.
interface as_lsu_core_if #(
   parameter int unsigned addr_width = 32
);
   logic                  req_i;
   logic                  we_i;
   logic [2:0]            funct3_i;
   logic [addr_width-1:0] addr_i;
   logic [63:0]           wdata_i;
   logic                  ready_o;
   logic                  rvalid_o;
   logic [63:0]           rdata_o;
   logic                  err_o;

   modport master (
      output req_i, we_i, funct3_i, addr_i, wdata_i,
      input  ready_o, rvalid_o, rdata_o, err_o
   );
   modport slave (
      input  req_i, we_i, funct3_i, addr_i, wdata_i,
      output ready_o, rvalid_o, rdata_o, err_o
   );
endinterface

interface as_lsu_mem_if #(
   parameter int unsigned addr_width = 32
);
   logic                  mem_en_o;
   logic                  mem_we_o;
   logic [addr_width-4:0] mem_addr_o;
   logic [63:0]           mem_wdata_o;
   logic [63:0]           mem_rdata_i;

   modport master (
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );
   modport slave (
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/as_lsu_ctrl.sv
// Load/store sequencer for a 64-bit SRAM without byte enables: extends sub-word loads,
// does read-modify-write for sub-word stores, flags bad accesses and owns the GPIO register.
module as_lsu_ctrl #(
   parameter int unsigned           addr_width = 32,
   parameter int unsigned           nr_gpios   = 8,
   parameter logic [addr_width-1:0] gpio_addr  = 'h0000_1000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   as_lsu_core_if.slave        core,
   as_lsu_mem_if.master        mem,
   output logic [nr_gpios-1:0] gpio_o,
   output logic                cs_o
);
   typedef enum logic [2:0] {IDLE, RD, LDAT, MRG, WR, RESP} state_t;
   state_t state;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [2:0]  off_q;
   logic [63:0] wdata_q;

   logic        illegal, misalign, is_gpio;
   logic [63:0] gpio_ext;
   logic [5:0]  sh;
   logic [63:0] shifted, load_val, mask, merge_val;

   assign core.ready_o = (state == IDLE);

   always_comb begin
      illegal  = core.we_i ? core.funct3_i[2] : (core.funct3_i == 3'b111);
      misalign = 1'b0;
      case (core.funct3_i[1:0])
         2'b01:   misalign = core.addr_i[0];
         2'b10:   misalign = |core.addr_i[1:0];
         2'b11:   misalign = |core.addr_i[2:0];
         default: misalign = 1'b0;
      endcase
      is_gpio = (core.addr_i == gpio_addr);
      gpio_ext = '0;
      gpio_ext[nr_gpios-1:0] = gpio_o;
   end

   // Lane extraction for loads and lane replacement for sub-word stores share the byte shift.
   always_comb begin
      sh      = {off_q, 3'b000};
      shifted = mem.mem_rdata_i >> sh;
      case (f3_q)
         3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
         3'b100:  load_val = {56'd0, shifted[7:0]};
         3'b101:  load_val = {48'd0, shifted[15:0]};
         3'b110:  load_val = {32'd0, shifted[31:0]};
         default: load_val = shifted;
      endcase
      case (f3_q[1:0])
         2'b00:   mask = 64'h0000_0000_0000_00FF;
         2'b01:   mask = 64'h0000_0000_0000_FFFF;
         default: mask = 64'h0000_0000_FFFF_FFFF;
      endcase
      merge_val = (mem.mem_rdata_i & ~(mask << sh)) | ((wdata_q & mask) << sh);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state            <= IDLE;
         gpio_o           <= '0;
         cs_o             <= 1'b0;
         core.rvalid_o    <= 1'b0;
         core.err_o       <= 1'b0;
         core.rdata_o     <= '0;
         mem.mem_en_o     <= 1'b0;
         mem.mem_we_o     <= 1'b0;
         mem.mem_addr_o   <= '0;
         mem.mem_wdata_o  <= '0;
         we_q             <= 1'b0;
         f3_q             <= '0;
         off_q            <= '0;
         wdata_q          <= '0;
      end else begin
         cs_o            <= 1'b0;
         core.rvalid_o   <= 1'b0;
         mem.mem_en_o    <= 1'b0;
         mem.mem_we_o    <= 1'b0;
         mem.mem_wdata_o <= '0;
         case (state)
            IDLE: if (core.req_i) begin
               we_q    <= core.we_i;
               f3_q    <= core.funct3_i;
               off_q   <= core.addr_i[2:0];
               wdata_q <= core.wdata_i;
               if (illegal || misalign) begin
                  core.err_o    <= 1'b1;
                  core.rvalid_o <= 1'b1;
                  state         <= RESP;
               end else if (is_gpio) begin
                  if (core.we_i) begin
                     gpio_o <= core.wdata_i[nr_gpios-1:0];
                     cs_o   <= 1'b1;
                  end else begin
                     core.rdata_o <= gpio_ext;
                  end
                  core.rvalid_o <= 1'b1;
                  state         <= RESP;
               end else if (core.we_i && core.funct3_i[1:0] == 2'b11) begin
                  mem.mem_en_o    <= 1'b1;
                  mem.mem_we_o    <= 1'b1;
                  mem.mem_addr_o  <= core.addr_i[addr_width-1:3];
                  mem.mem_wdata_o <= core.wdata_i;
                  state           <= WR;
               end else begin
                  mem.mem_en_o   <= 1'b1;
                  mem.mem_addr_o <= core.addr_i[addr_width-1:3];
                  state          <= RD;
               end
            end
            RD:   state <= we_q ? MRG : LDAT;
            LDAT: begin
               core.rdata_o  <= load_val;
               core.rvalid_o <= 1'b1;
               state         <= RESP;
            end
            MRG: begin
               mem.mem_en_o    <= 1'b1;
               mem.mem_we_o    <= 1'b1;
               mem.mem_wdata_o <= merge_val;
               state           <= WR;
            end
            WR: begin
               core.rvalid_o <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               core.rdata_o <= '0;
               core.err_o   <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_as_lsu_ctrl.sv
// Bench for as_lsu_ctrl: SRAM model, byte-level reference model, directed table,
// reset-abort and sub-byte sequences, then randomized accesses.
module tb_as_lsu_ctrl;
   localparam logic [31:0] GPIO = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   as_lsu_core_if #(.addr_width(32)) cif();
   as_lsu_mem_if  #(.addr_width(32)) mif();
   logic [7:0] gpio;
   logic       cs;

   as_lsu_ctrl #(.addr_width(32), .nr_gpios(8), .gpio_addr(GPIO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .core(cif), .mem(mif), .gpio_o(gpio), .cs_o(cs)
   );

   logic [63:0] sram [16];
   logic [63:0] rd_q = '0;
   logic        pre_we = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [63:0] pre_val = '0;
   assign mif.mem_rdata_i = rd_q;

   always @(posedge clk) begin
      if (pre_we) sram[pre_idx] <= pre_val;
      else if (mif.mem_en_o) begin
         if (mif.mem_we_o) sram[mif.mem_addr_o[3:0]] <= mif.mem_wdata_o;
         else rd_q <= sram[mif.mem_addr_o[3:0]];
      end
   end

   int en_cnt, wr_cnt, cs_cnt, rv_cnt;
   logic [63:0] last_wdata;
   logic [28:0] last_waddr;
   always @(negedge clk) begin
      if (mif.mem_en_o) en_cnt <= en_cnt + 1;
      if (mif.mem_en_o && mif.mem_we_o) begin
         wr_cnt     <= wr_cnt + 1;
         last_wdata <= mif.mem_wdata_o;
         last_waddr <= mif.mem_addr_o;
      end
      if (cs) cs_cnt <= cs_cnt + 1;
      if (cif.rvalid_o) rv_cnt <= rv_cnt + 1;
   end

   int checks = 0, errors = 0;
   logic [63:0] ref_mem [16];
   logic [7:0]  ref_gpio = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [63:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 4'(idx); pre_val = val;
      @(posedge clk); #1;
      pre_we = 1'b0;
      ref_mem[idx] = val;
   endtask

   // Reference: byte-granular view of memory, independent of any lane/mask encoding.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [63:0] wd, output logic [63:0] er, output bit ee,
                        output int elat, output int een, output int ewr, output int ecs);
      int nb;
      bit bad;
      int idx, off;
      logic [63:0] ones;
      nb   = 1 << f3[1:0];
      bad  = (we ? (f3 > 3) : (f3 == 7)) || ((a % nb) != 0);
      er = '0; ee = 0; elat = 0; een = 0; ewr = 0; ecs = 0;
      ones = '1;
      idx  = int'(a[6:3]);
      off  = int'(a[2:0]);
      if (bad) begin
         ee = 1; elat = 1;
      end else if (a == GPIO) begin
         elat = 1;
         if (we) begin ref_gpio = wd[7:0]; ecs = 1; end
         else er = {56'd0, ref_gpio};
      end else if (!we) begin
         for (int b = 0; b < nb; b++) er = er | (64'(ref_mem[idx][8*(off+b) +: 8]) << (8*b));
         if (f3 < 4 && nb < 8 && er[8*nb-1]) er = er | (ones << (8*nb));
         elat = 3; een = 1;
      end else begin
         for (int b = 0; b < nb; b++) ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
         ewr = 1;
         een  = (nb == 8) ? 1 : 2;
         elat = (nb == 8) ? 2 : 4;
      end
   endtask

   task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [63:0] wd, output logic [63:0] got_rd,
                      output bit got_err, output int got_lat);
      logic [63:0] er;
      bit ee;
      int elat, een, ewr, ecs, n;
      model(we, f3, a, wd, er, ee, elat, een, ewr, ecs);
      @(negedge clk);
      cif.req_i = 1'b1; cif.we_i = we; cif.funct3_i = f3; cif.addr_i = a; cif.wdata_i = wd;
      n = 0;
      while (!cif.ready_o && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      cif.req_i = 1'b0;
      en_cnt = 0; wr_cnt = 0; cs_cnt = 0;
      got_lat = 0;
      do begin @(negedge clk); got_lat++; end while (!cif.rvalid_o && got_lat < 20);
      got_rd  = cif.rdata_o;
      got_err = cif.err_o;
      #1;
      check("latency", 64'(got_lat), 64'(elat));
      check("rdata", got_rd, er);
      check("err", 64'(got_err), 64'(ee));
      check("mem_en_cycles", 64'(en_cnt), 64'(een));
      check("writes", 64'(wr_cnt), 64'(ewr));
      check("cs_pulses", 64'(cs_cnt), 64'(ecs));
      check("gpio", 64'(gpio), 64'(ref_gpio));
      if (ewr != 0) begin
         check("write_data", last_wdata, ref_mem[int'(a[6:3])]);
         check("write_addr", 64'(last_waddr), 64'(a[31:3]));
      end
      @(negedge clk);
      check("post_resp_clear", {62'd0, cif.rvalid_o, cif.err_o} | cif.rdata_o, 64'd0);
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rd;
      bit          err;
      int          lat;
   } vec_t;
   vec_t tbl [15];

   initial begin
      logic [63:0] rd;
      bit          er;
      int          lat;

      cif.req_i = 1'b0; cif.we_i = 1'b0; cif.funct3_i = '0; cif.addr_i = '0; cif.wdata_i = '0;
      en_cnt = 0; wr_cnt = 0; cs_cnt = 0; rv_cnt = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;

      tbl[0]  = '{0, 3'b001, 32'h0,  64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 0, 3};
      tbl[1]  = '{0, 3'b101, 32'h2,  64'h0, 64'h0000_0000_0000_1234, 0, 3};
      tbl[2]  = '{0, 3'b001, 32'h4,  64'h0, 64'h0000_0000_0000_7FFF, 0, 3};
      tbl[3]  = '{0, 3'b001, 32'h6,  64'h0, 64'hFFFF_FFFF_FFFF_8000, 0, 3};
      tbl[4]  = '{0, 3'b001, 32'h3,  64'h0, 64'h0, 1, 1};
      tbl[5]  = '{0, 3'b010, 32'h2,  64'h0, 64'h0, 1, 1};
      tbl[6]  = '{0, 3'b011, 32'h4,  64'h0, 64'h0, 1, 1};
      tbl[7]  = '{0, 3'b111, 32'h0,  64'h0, 64'h0, 1, 1};
      tbl[8]  = '{1, 3'b001, 32'h2,  64'hBEEF, 64'h0, 0, 4};
      tbl[9]  = '{0, 3'b011, 32'h0,  64'h0, 64'h8000_7FFF_BEEF_ABCD, 0, 3};
      tbl[10] = '{1, 3'b011, GPIO,   64'd1, 64'h0, 0, 1};
      tbl[11] = '{1, 3'b011, GPIO,   64'd3, 64'h0, 0, 1};
      tbl[12] = '{1, 3'b011, GPIO,   64'd5, 64'h0, 0, 1};
      tbl[13] = '{1, 3'b011, GPIO,   64'd7, 64'h0, 0, 1};
      tbl[14] = '{0, 3'b011, GPIO,   64'h0, 64'd7, 0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs_zero",
            64'(|{cif.rvalid_o, cif.err_o, cif.rdata_o, mif.mem_en_o, mif.mem_we_o,
                  mif.mem_addr_o, mif.mem_wdata_o, gpio, cs}), 64'd0);
      check("reset_ready", 64'(cif.ready_o), 64'd1);
      for (int i = 0; i < 16; i++) preload(i, '0);
      rst_n = 1'b1;

      preload(0, 64'h8000_7FFF_1234_ABCD);
      for (int i = 0; i < 15; i++) begin
         run(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         check($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].err));
         check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      end

      // Abort a sub-word store in its merge cycle; the write-back must never happen.
      preload(1, 64'h1122_3344_5566_7788);
      @(negedge clk);
      cif.req_i = 1'b1; cif.we_i = 1'b1; cif.funct3_i = 3'b000; cif.addr_i = 32'h9;
      cif.wdata_i = 64'h55;
      @(posedge clk); #1;
      cif.req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wr_cnt = 0; rv_cnt = 0;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outputs_zero",
            64'(|{cif.rvalid_o, cif.err_o, cif.rdata_o, mif.mem_en_o, mif.mem_we_o,
                  mif.mem_addr_o, mif.mem_wdata_o, gpio, cs}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      ref_gpio = '0;
      check("abort_no_write", 64'(wr_cnt), 64'd0);
      check("abort_no_rvalid", 64'(rv_cnt), 64'd0);
      check("abort_sram_intact", sram[1], 64'h1122_3344_5566_7788);
      check("abort_gpio_cleared", 64'(gpio), 64'd0);

      preload(0, 64'h0);
      run(1, 3'b000, 32'h5, 64'hAA, rd, er, lat);
      run(0, 3'b011, 32'h0, 64'h0, rd, er, lat);
      check("sb_merged_dword", rd, 64'h0000_AA00_0000_0000);
      run(0, 3'b000, 32'h5, 64'h0, rd, er, lat);
      check("lb_sign", rd, 64'hFFFF_FFFF_FFFF_FFAA);
      run(0, 3'b100, 32'h5, 64'h0, rd, er, lat);
      check("lbu_zero", rd, 64'h0000_0000_0000_00AA);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) a = GPIO + 32'($urandom_range(0, 1) * $urandom_range(0, 7));
         else a = {25'd0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
         run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             {$urandom, $urandom}, rd, er, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
